logic_pod_lane_arbiter: RTL and testbench
=========================================

LOGIC_POD_LANE_ARBITER -- requirements
Module: logic_pod_lane_arbiter

Interface
REQ-001 Parameter BURST_WORDS, default 8; number of 16-bit compressed words packed into one output beat (fixed at 8 in this release).
REQ-002 Parameter COUNT_WIDTH, default 10; width of each per-lane FIFO occupancy count.
REQ-003 clk  in  1  DRAM-domain clock; all logic on rising edge.
REQ-004 rst_n  in  1  reset; asynchronous, active-low.
REQ-005 fifo_rd_count  in  8*COUNT_WIDTH  per-lane CDC FIFO occupancy in words, lane g at [g*COUNT_WIDTH +: COUNT_WIDTH].
REQ-006 fifo_rd_en  out  8  per-lane FIFO pop strobe, registered.
REQ-007 fifo_rd_data  in  8*17  per-lane FIFO read data {format, data[15:0]}, lane g at [g*17 +: 17], valid the cycle after fifo_rd_en[g].
REQ-008 flush  in  1  level request to drain partial lanes.
REQ-009 flush_done  out  1  all lanes drained while flush high.
REQ-010 out_valid  out  1  output beat valid.
REQ-011 out_ready  in  1  downstream (DRAM write path) accepts beat.
REQ-012 out_data  out  128  packed words, word i at [16*i +: 16].
REQ-013 out_formats  out  8  format bit of word i at bit i.
REQ-014 out_lane  out  3  source lane of beat.
REQ-015 out_words  out  4  valid word count in beat, 1..8.

Function
REQ-016 States: IDLE, READ, OUTPUT; only IDLE evaluates eligibility.
REQ-017 Lane eligible: count >= 8, or (flush high and count > 0).
REQ-018 Round-robin: grant first eligible lane scanning ptr, ptr+1, ... mod 8; on grant ptr <= granted lane + 1 mod 8; ptr = 0 after reset.
REQ-019 On grant: latch lane and n = min(count, 8); go to READ next cycle; no eligible lane -> stay IDLE.
REQ-020 READ: fifo_rd_en[lane] high for exactly n consecutive cycles starting the cycle after grant; at most one fifo_rd_en bit high in any cycle.
REQ-021 Word k (k = 0..n-1) captured from fifo_rd_data the cycle after its pop into out_data word k and out_formats bit k.
REQ-022 Words n..7 of out_data and out_formats bits n..7 SHALL be zero.
REQ-023 out_valid rises the cycle after word n-1 is captured; grant-to-out_valid latency = n+2 cycles.
REQ-024 OUTPUT: out_valid, out_data, out_formats, out_lane, out_words held stable until out_valid && out_ready; then out_valid low next cycle, state IDLE.
REQ-025 out_ready ignored while out_valid low; out_ready high before out_valid does not shorten latency.
REQ-026 fifo_rd_count changes during READ/OUTPUT do not alter latched n.
REQ-027 flush rising during READ/OUTPUT does not affect current beat; applies at next IDLE.
REQ-028 flush_done = flush && state IDLE && all eight counts zero, registered (one-cycle delay); low otherwise.
REQ-029 Beat throughput: at most one beat per n+3 cycles when out_ready held high.
REQ-030 Count values above 8 yield n = 8; no lane ever popped when count = 0.

Reset
REQ-031 While rst_n low: state IDLE, ptr 0, fifo_rd_en 0, out_valid 0, out_data 0, out_formats 0, out_lane 0, out_words 0, flush_done 0.
REQ-032 Reset mid-READ/OUTPUT abandons the beat; popped words discarded; first grant after release follows REQ-018 from ptr 0.

Verification
REQ-033 Lane 3 count 8, others 0, out_ready 1 -> 8 pops on lane 3 only, out_valid 10 cycles after grant, out_lane 3, out_words 8, data words in pop order.
REQ-034 All lanes count 20, out_ready 1 -> beats from lanes 0,1,...,7,0 in order, each out_words 8, never two rd_en bits high.
REQ-035 Lane 5 count 3, flush 0 -> no pops; assert flush -> 3 pops, out_words 3, words 3..7 and formats 3..7 zero; count then 0 -> flush_done 1.
REQ-036 Lane 0 beat valid, out_ready low 20 cycles -> outputs stable, no pops on any lane; out_ready high -> beat accepted, IDLE next.
REQ-037 rst_n low at 4th pop of a beat -> fifo_rd_en and out_valid 0 immediately; after release with lane 2 count 8 -> lane 2 granted, full beat produced.

Source files
------------

// File: rtl/logic_pod_lane_arbiter.sv
// Round-robin arbiter that drains eight per-lane CDC FIFOs into 128-bit beats of
// up to eight 16-bit compressed words, with a flush path for partially filled lanes.

module logic_pod_lane_arbiter_elig #(
  parameter int BURST_WORDS = 8,
  parameter int COUNT_WIDTH = 10
) (
  input  logic [COUNT_WIDTH-1:0] i_count,
  input  logic                   i_flush,
  output logic                   o_elig,
  output logic [3:0]             o_n
);
  logic w_full;

  assign w_full = (i_count >= COUNT_WIDTH'(BURST_WORDS));
  assign o_elig = w_full || (i_flush && (i_count != '0));
  assign o_n    = w_full ? 4'(BURST_WORDS) : i_count[3:0];
endmodule

module logic_pod_lane_arbiter #(
  parameter int BURST_WORDS = 8,
  parameter int COUNT_WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [8*COUNT_WIDTH-1:0] fifo_rd_count,
  output logic [7:0]               fifo_rd_en,
  input  logic [8*17-1:0]          fifo_rd_data,
  input  logic                     flush,
  output logic                     flush_done,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [127:0]             out_data,
  output logic [7:0]               out_formats,
  output logic [2:0]               out_lane,
  output logic [3:0]               out_words
);
  localparam int NUM_LANES = 8;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_OUTPUT} state_t;

  state_t                              r_state;
  logic [2:0]                          r_ptr;
  logic [2:0]                          r_lane;
  logic [3:0]                          r_n;
  logic [3:0]                          r_pop_cnt;
  logic [3:0]                          r_cap_cnt;
  logic                                r_cap_vld;
  logic [NUM_LANES-1:0]                r_rd_en;
  logic [NUM_LANES-1:0][15:0]          r_data;
  logic [NUM_LANES-1:0]                r_fmt;
  logic                                r_out_valid;
  logic                                r_flush_done;

  logic [NUM_LANES-1:0][COUNT_WIDTH-1:0] w_cnt;
  logic [NUM_LANES-1:0][16:0]            w_rd;
  logic [NUM_LANES-1:0]                  w_elig;
  logic [NUM_LANES-1:0][3:0]             w_n;
  logic                                  w_found;
  logic [2:0]                            w_gnt;
  logic [16:0]                           w_word;

  assign w_cnt  = fifo_rd_count;
  assign w_rd   = fifo_rd_data;
  assign w_word = w_rd[r_lane];

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    logic_pod_lane_arbiter_elig #(
      .BURST_WORDS(BURST_WORDS),
      .COUNT_WIDTH(COUNT_WIDTH)
    ) u_elig (
      .i_count(w_cnt[g]),
      .i_flush(flush),
      .o_elig (w_elig[g]),
      .o_n    (w_n[g])
    );
  end

  // First eligible lane scanning upward from the round-robin pointer.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (!w_found && w_elig[r_ptr + 3'(i)]) begin
        w_found = 1'b1;
        w_gnt   = r_ptr + 3'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_ptr        <= '0;
      r_lane       <= '0;
      r_n          <= '0;
      r_pop_cnt    <= '0;
      r_cap_cnt    <= '0;
      r_cap_vld    <= 1'b0;
      r_rd_en      <= '0;
      r_data       <= '0;
      r_fmt        <= '0;
      r_out_valid  <= 1'b0;
      r_flush_done <= 1'b0;
    end else begin
      r_flush_done <= flush && (r_state == S_IDLE) && (fifo_rd_count == '0);
      // Read data lags the pop strobe by one cycle.
      r_cap_vld    <= |r_rd_en;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_lane    <= w_gnt;
            r_n       <= w_n[w_gnt];
            r_rd_en   <= NUM_LANES'(1) << w_gnt;
            r_pop_cnt <= 4'd1;
            r_cap_cnt <= '0;
            r_data    <= '0;
            r_fmt     <= '0;
            r_ptr     <= w_gnt + 3'd1;
            r_state   <= S_READ;
          end
        end
        S_READ: begin
          if (r_pop_cnt < r_n) r_pop_cnt <= r_pop_cnt + 4'd1;
          else                 r_rd_en   <= '0;
          if (r_cap_vld) begin
            r_data[r_cap_cnt[2:0]] <= w_word[15:0];
            r_fmt[r_cap_cnt[2:0]]  <= w_word[16];
            r_cap_cnt              <= r_cap_cnt + 4'd1;
            if (r_cap_cnt == r_n - 4'd1) begin
              r_out_valid <= 1'b1;
              r_state     <= S_OUTPUT;
            end
          end
        end
        S_OUTPUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign fifo_rd_en  = r_rd_en;
  assign flush_done  = r_flush_done;
  assign out_valid   = r_out_valid;
  assign out_data    = r_data;
  assign out_formats = r_fmt;
  assign out_lane    = r_lane;
  assign out_words   = r_n;
endmodule

// File: tb/tb_logic_pod_lane_arbiter.sv
// Bench for logic_pod_lane_arbiter: queue-based FIFO model plus beat-level reference
// (grant order, beat contents, timing windows) driven by directed and random steps.

module tb_logic_pod_lane_arbiter;
  localparam int CW = 10;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [8*CW-1:0] fifo_rd_count = '0;
  logic [7:0]      fifo_rd_en;
  logic [8*17-1:0] fifo_rd_data = '0;
  logic            flush = 1'b0;
  logic            flush_done;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [127:0]    out_data;
  logic [7:0]      out_formats;
  logic [2:0]      out_lane;
  logic [3:0]      out_words;

  logic_pod_lane_arbiter #(.BURST_WORDS(8), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_rd_count(fifo_rd_count), .fifo_rd_en(fifo_rd_en),
    .fifo_rd_data(fifo_rd_data), .flush(flush), .flush_done(flush_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_formats(out_formats), .out_lane(out_lane), .out_words(out_words)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0, n_err = 0;
  logic [16:0] q[8][$];
  int          cyc = 0;
  bit          busy = 0, vis = 0, pend_v = 0;
  int          first_rd, ptr = 0, e_lane, e_n, pend_l, beats = 0, last_words = 0;
  logic [16:0] e_w[8];
  logic [16:0] pend_w;
  int          lane_log[$];

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int cnt(int l);
    return int'(fifo_rd_count[l*CW +: CW]);
  endfunction

  task automatic drive_counts();
    for (int g = 0; g < 8; g++)
      fifo_rd_count[g*CW +: CW] = CW'((q[g].size() > 1023) ? 1023 : q[g].size());
  endtask

  task automatic push(int l, int k);
    for (int i = 0; i < k; i++) q[l].push_back(17'($urandom));
    drive_counts();
  endtask

  // One clock: check outputs produced by the last edge against the reference,
  // then play the FIFO side (pops, read data one cycle after the pop).
  task automatic step();
    logic [127:0] ed;
    logic [7:0]   ef;
    int           pl, d;
    @(negedge clk);
    cyc++;
    if (!rst_n) begin
      chk("rst_rd_en", fifo_rd_en, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_data", {out_data, out_formats, out_lane, out_words}, 0);
      chk("rst_flush_done", flush_done, 0);
    end else begin
      chk("flush_done", flush_done, flush && !busy && (fifo_rd_count == '0));
      if (!busy) begin
        pl = -1;
        for (int i = 0; i < 8; i++) begin
          int l, c;
          l = (ptr + i) % 8;
          c = cnt(l);
          if (pl < 0 && (c >= 8 || (flush && c > 0))) pl = l;
        end
        chk("grant", fifo_rd_en, (pl < 0) ? 0 : (1 << pl));
        chk("idle_valid", out_valid, 0);
        if (pl >= 0) begin
          busy = 1; vis = 0; first_rd = cyc; e_lane = pl;
          e_n = (cnt(pl) > 8) ? 8 : cnt(pl);
          for (int k = 0; k < 8; k++) e_w[k] = (k < e_n) ? q[pl][k] : '0;
          ptr = (pl + 1) % 8;
        end
      end else begin
        d = cyc - first_rd;
        if (d < e_n) begin
          chk("pop_lane", fifo_rd_en, 1 << e_lane);
          chk("early_valid", out_valid, 0);
        end else if (d == e_n) begin
          chk("pop_stop", fifo_rd_en, 0);
          chk("early_valid", out_valid, 0);
        end else begin
          chk("out_no_pop", fifo_rd_en, 0);
          if (vis && out_ready) begin
            chk("accept_drop", out_valid, 0);
            busy = 0; beats++; lane_log.push_back(e_lane); last_words = e_n;
          end else begin
            ed = '0; ef = '0;
            for (int k = 0; k < 8; k++) begin
              ed[16*k +: 16] = e_w[k][15:0];
              ef[k]          = e_w[k][16];
            end
            chk("out_valid", out_valid, 1);
            chk("out_lane", out_lane, e_lane);
            chk("out_words", out_words, e_n);
            chk("out_data", out_data, ed);
            chk("out_formats", out_formats, ef);
            vis = 1;
          end
        end
      end
    end
    chk("onehot", $countones(fifo_rd_en) <= 1, 1);
    for (int g = 0; g < 8; g++)
      fifo_rd_data[g*17 +: 17] = (pend_v && pend_l == g) ? pend_w : 17'($urandom);
    pend_v = 0;
    for (int g = 0; g < 8; g++) begin
      if (fifo_rd_en[g]) begin
        if (q[g].size() == 0) chk("pop_empty", g, 8);
        else begin
          pend_w = q[g].pop_front(); pend_v = 1; pend_l = g;
        end
      end
    end
    drive_counts();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; busy = 0; pend_v = 0; ptr = 0; flush = 0; out_ready = 0;
    for (int g = 0; g < 8; g++) q[g].delete();
    drive_counts();
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic run_beats(int k, int limit);
    int target;
    target = beats + k;
    for (int i = 0; i < limit && beats < target; i++) step();
    chk("beat_timeout", beats, target);
  endtask

  initial begin
    int b0;
    // Single full lane: lane 3, eight words.
    do_reset();
    push(3, 8); out_ready = 1;
    run_beats(1, 30);
    chk("s1_lane", lane_log[$], 3);
    chk("s1_words", last_words, 8);

    // Every lane loaded: strict round-robin from lane 0 with wrap.
    do_reset();
    for (int g = 0; g < 8; g++) push(g, 20);
    out_ready = 1; lane_log.delete();
    run_beats(9, 200);
    for (int i = 0; i < 9; i++) chk("s2_order", lane_log[i], i % 8);

    // Partial lane waits for flush, then drains and flush_done follows.
    do_reset();
    push(5, 3); out_ready = 1; b0 = beats;
    for (int i = 0; i < 30; i++) step();
    chk("s3_no_beat", beats, b0);
    flush = 1;
    run_beats(1, 40);
    chk("s3_words", last_words, 3);
    for (int i = 0; i < 4; i++) step();
    chk("s3_flush_done", flush_done, 1);
    flush = 0;

    // Back-pressure: beat held with out_ready low for 20 cycles.
    do_reset();
    push(0, 8); out_ready = 0; b0 = beats;
    for (int i = 0; i < 40 && !out_valid; i++) step();
    for (int i = 0; i < 20; i++) step();
    chk("s4_held", {busy, beats}, {1'b1, b0});
    out_ready = 1;
    run_beats(1, 5);

    // Reset on the fourth pop abandons the beat.
    do_reset();
    push(0, 8); out_ready = 1;
    for (int i = 0; i < 40 && !(busy && cyc - first_rd == 3); i++) step();
    chk("s5_at_pop4", busy && (cyc - first_rd == 3), 1);
    rst_n = 0;
    #1;
    chk("s5_rd_en_clr", fifo_rd_en, 0);
    chk("s5_valid_clr", out_valid, 0);
    busy = 0; pend_v = 0; ptr = 0;
    step();
    push(2, 8);
    rst_n = 1;
    run_beats(1, 30);
    chk("s5_lane", lane_log[$], 2);
    chk("s5_words", last_words, 8);

    // Random traffic, back-pressure and flush toggling.
    do_reset();
    b0 = beats;
    for (int i = 0; i < 3000; i++) begin
      step();
      for (int g = 0; g < 8; g++)
        if ($urandom_range(0, 9) == 0 && q[g].size() < 40) push(g, $urandom_range(1, 6));
      out_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 49) == 0) flush = ~flush;
    end
    chk("rand_progress", beats - b0 > 20, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
